// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//
// Shares one 32-bit asynchronous SRAM between the instruction-fetch (IF) read
// port and the data-memory (MEM) read/write port. One access runs at a time:
// the FSM grants a requester in IDLE, runs a read strobe (RD) or a
// setup/pulse/hold write sequence, and then pulses the granted port's ack for
// one cycle in DONE.
//
// Every ram_* pin and both acks come from flops. Their next values are decoded
// from the next state, so each pin changes together with the state.
//
// Parameters
//   WAIT_CYCLES  extra strobe cycles; oe_n/we_n stay low WAIT_CYCLES+1 cycles (0..7)
//   ADDR_W       SRAM word-address width; ram_addr = addr[ADDR_W+1:2]
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   if_*          IF read request/address, read data and one-cycle ack
//   mem_*         MEM request, write enable, byte selects, address, write data,
//                 read data and one-cycle ack
//   stall_req_o   high while either port has a request that is not yet acked
//   ram_*         SRAM data bus (inout), word address and active-low controls
//
// Build option
//   SRAM_ARB_RR_EN  defined: a same-cycle collision goes to the port that was
//                   not granted last. Undefined: MEM always wins over IF.

module sram_port_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_data_i,
    output logic [31:0]       mem_data_o,
    output logic              mem_ack_o,
    output logic              stall_req_o,
    inout  wire  [31:0]       ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } state_e;

    localparam logic [2:0] WaitLoad = 3'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                gnt_mem_q, gnt_mem_d;
    logic [3:0]          sel_q, sel_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         if_data_q, if_data_d;
    logic [31:0]         mem_data_q, mem_data_d;

    // Registered pin drivers.
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [3:0]          be_n_q, be_n_d;
    logic                drive_q, drive_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;

    logic                pick_mem;
    logic                any_req;

    // Address bits outside the SRAM word range are intentionally ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

    assign any_req = if_req_i | mem_req_i;

`ifdef SRAM_ARB_RR_EN
    // rr_q = 1 favours MEM on the next collision.
    logic rr_q, rr_d;

    assign pick_mem = mem_req_i & (~if_req_i | rr_q);

    always_comb begin
        rr_d = rr_q;
        if (state_q == StIdle && any_req) begin
            rr_d = ~pick_mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // MEM holds the older instruction, so it always wins.
    assign pick_mem = mem_req_i;
`endif

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_mem_d  = gnt_mem_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
        mem_data_d = mem_data_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt_mem_d = pick_mem;
                    if (pick_mem) begin
                        addr_d  = mem_addr_i[ADDR_W+1:2];
                        sel_d   = mem_sel_i;
                        wdata_d = mem_data_i;
                        state_d = mem_we_i ? StWrSetup : StRd;
                    end else begin
                        addr_d  = if_addr_i[ADDR_W+1:2];
                        sel_d   = 4'hF;
                        state_d = StRd;
                    end
                end
            end
            StRd: begin
                if (cnt_q == 3'd0) begin
                    if (gnt_mem_q) begin
                        mem_data_d = ram_data;
                    end else begin
                        if_data_d = ram_data;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrSetup: begin
                state_d = StWrPulse;
            end
            StWrPulse: begin
                if (cnt_q == 3'd0) begin
                    state_d = StWrHold;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StWrHold: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The strobe counter restarts whenever a new state is entered.
        if (state_d != state_q) begin
            cnt_d = WaitLoad;
        end
    end

    // Pin values for the upcoming cycle, decoded from the next state.
    always_comb begin
        ce_n_d    = ~(state_d inside {StRd, StWrSetup, StWrPulse, StWrHold});
        oe_n_d    = (state_d != StRd);
        we_n_d    = (state_d != StWrPulse);
        be_n_d    = ce_n_d ? 4'hF : ~sel_d;
        drive_d   = (state_d inside {StWrSetup, StWrPulse, StWrHold});
        if_ack_d  = (state_d == StDone) & ~gnt_mem_d;
        mem_ack_d = (state_d == StDone) & gnt_mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            gnt_mem_q  <= 1'b1;
            sel_q      <= 4'h0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            if_data_q  <= 32'h0;
            mem_data_q <= 32'h0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
            drive_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_mem_q  <= gnt_mem_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
            mem_data_q <= mem_data_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            drive_q    <= drive_d;
            if_ack_q   <= if_ack_d;
            mem_ack_q  <= mem_ack_d;
        end
    end

    assign ram_data    = drive_q ? wdata_q : 32'bz;
    assign ram_addr    = addr_q;
    assign ram_be_n    = be_n_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;
    assign if_ack_o    = if_ack_q;
    assign mem_ack_o   = mem_ack_q;
    assign stall_req_o = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: instance A (WAIT_CYCLES=1) runs a vector
// table plus reset, collision and dropped-request sequences; instance B
// (WAIT_CYCLES=0) runs back-to-back IF reads. Each instance has a small SRAM
// model, and a pull-down on the bus reads as 0 when nothing drives it.

module tb_sram_port_arbiter;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instance A: WAIT_CYCLES = 1 ----------------
    logic        a_if_req, a_mem_req, a_mem_we;
    logic [31:0] a_if_addr, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_sel;
    logic [31:0] a_if_data, a_mem_data;
    logic        a_if_ack, a_mem_ack, a_stall;
    tri0  [31:0] a_ram_data;
    logic [19:0] a_ram_addr;
    logic [3:0]  a_ram_be_n;
    logic        a_ram_ce_n, a_ram_oe_n, a_ram_we_n;
    logic [31:0] a_sram [256];

    sram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) u_a (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (a_if_req),
        .if_addr_i   (a_if_addr),
        .if_data_o   (a_if_data),
        .if_ack_o    (a_if_ack),
        .mem_req_i   (a_mem_req),
        .mem_we_i    (a_mem_we),
        .mem_sel_i   (a_mem_sel),
        .mem_addr_i  (a_mem_addr),
        .mem_data_i  (a_mem_wdata),
        .mem_data_o  (a_mem_data),
        .mem_ack_o   (a_mem_ack),
        .stall_req_o (a_stall),
        .ram_data    (a_ram_data),
        .ram_addr    (a_ram_addr),
        .ram_be_n    (a_ram_be_n),
        .ram_ce_n    (a_ram_ce_n),
        .ram_oe_n    (a_ram_oe_n),
        .ram_we_n    (a_ram_we_n)
    );

    assign a_ram_data = (!a_ram_ce_n && !a_ram_oe_n && a_ram_we_n) ?
                        a_sram[a_ram_addr[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (!a_ram_ce_n && !a_ram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!a_ram_be_n[b]) a_sram[a_ram_addr[7:0]][8*b +: 8] <= a_ram_data[8*b +: 8];
            end
        end
    end

    // ---------------- instance B: WAIT_CYCLES = 0 ----------------
    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic [31:0] b_if_data, b_mem_data;
    logic        b_if_ack, b_mem_ack, b_stall;
    tri0  [31:0] b_ram_data;
    logic [19:0] b_ram_addr;
    logic [3:0]  b_ram_be_n;
    logic        b_ram_ce_n, b_ram_oe_n, b_ram_we_n;
    logic [31:0] b_sram [256];

    sram_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(20)) u_b (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (b_if_req),
        .if_addr_i   (b_if_addr),
        .if_data_o   (b_if_data),
        .if_ack_o    (b_if_ack),
        .mem_req_i   (1'b0),
        .mem_we_i    (1'b0),
        .mem_sel_i   (4'h0),
        .mem_addr_i  (32'h0),
        .mem_data_i  (32'h0),
        .mem_data_o  (b_mem_data),
        .mem_ack_o   (b_mem_ack),
        .stall_req_o (b_stall),
        .ram_data    (b_ram_data),
        .ram_addr    (b_ram_addr),
        .ram_be_n    (b_ram_be_n),
        .ram_ce_n    (b_ram_ce_n),
        .ram_oe_n    (b_ram_oe_n),
        .ram_we_n    (b_ram_we_n)
    );

    assign b_ram_data = (!b_ram_ce_n && !b_ram_oe_n && b_ram_we_n) ?
                        b_sram[b_ram_addr[7:0]] : 32'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_mem;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [19:0] exp_ra;
        logic [3:0]  exp_be;
        int          exp_lat;
        int          exp_oe;
        int          exp_we;
        int          exp_drv;
    } vec_t;

    vec_t vecs [8];

    // One access on instance A; inputs change on negedges, outputs sampled there.
    task automatic a_access(input vec_t v, output logic [31:0] rdata, output int lat,
                            output int oe_cnt, output int we_cnt, output int drv_cnt,
                            output int acks, output logic [19:0] ra, output logic [3:0] be,
                            output logic stall_bad);
        logic ack;
        logic st;
        rdata = 32'h0; lat = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; acks = 0;
        ra = '0; be = '0; stall_bad = 1'b0;
        @(negedge clk);
        if (v.is_mem) begin
            a_mem_req = 1'b1; a_mem_we = v.we; a_mem_sel = v.sel;
            a_mem_addr = v.addr; a_mem_wdata = v.wdata;
        end else begin
            a_if_req = 1'b1; a_if_addr = v.addr;
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            st = a_stall;
            if (k == 1) begin
                ra = a_ram_addr;
                be = a_ram_be_n;
            end
            if (!a_ram_oe_n) oe_cnt++;
            if (!a_ram_we_n) we_cnt++;
            if (a_ram_oe_n && a_ram_data != 32'h0) drv_cnt++;
            ack = v.is_mem ? a_mem_ack : a_if_ack;
            if (ack) begin
                acks++;
                if (st) stall_bad = 1'b1;
                if (lat == 0) begin
                    lat = k;
                    rdata = v.is_mem ? a_mem_data : a_if_data;
                end
                a_if_req = 1'b0;
                a_mem_req = 1'b0;
            end else if (lat == 0 && !st) begin
                stall_bad = 1'b1;
            end
            if (lat != 0 && k >= lat + 2) break;
        end
    endtask

    initial begin
        logic [31:0] rdata;
        int          lat, oe_cnt, we_cnt, drv_cnt, acks;
        logic [19:0] ra;
        logic [3:0]  be;
        logic        stall_bad;
        logic        found;
        int          mem_k, if_k, ack_k;
        logic        st, pending, exp_mem_first;
        int          k1, k2, n;
        logic [31:0] d1, d2;

        for (int i = 0; i < 256; i++) begin
            a_sram[i] = 32'h0;
            b_sram[i] = 32'h0;
        end
        a_sram[8'h04] = 32'h3C08BFD0;
        a_sram[8'h40] = 32'h12345678;
        b_sram[0]     = 32'hA5A50001;
        b_sram[1]     = 32'h0BADF00D;

        //        mem  we   sel    addr          wdata         rdata         ra        be   lat oe we drv
        vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h80000010, 32'h0,        32'h3C08BFD0, 20'h00004, 4'h0, 3, 2, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h80000100, 32'hDEADBEEF, 32'h0,        20'h00040, 4'hC, 5, 0, 2, 4};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h80000100, 32'h0,        32'h1234BEEF, 20'h00040, 4'h0, 3, 2, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 4'hF, 32'hFFC00008, 32'hCAFEF00D, 32'h0,        20'h00002, 4'h0, 5, 0, 2, 4};
        vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h00000008, 32'h0,        32'hCAFEF00D, 20'h00002, 4'h0, 3, 2, 0, 0};
        vecs[5] = '{1'b1, 1'b0, 4'h4, 32'h80000010, 32'h0,        32'h3C08BFD0, 20'h00004, 4'hB, 3, 2, 0, 0};
        vecs[6] = '{1'b1, 1'b1, 4'h8, 32'h80000010, 32'hAB000000, 32'h0,        20'h00004, 4'h7, 5, 0, 2, 4};
        vecs[7] = '{1'b0, 1'b0, 4'h0, 32'h80000010, 32'h0,        32'hAB08BFD0, 20'h00004, 4'h0, 3, 2, 0, 0};

        rst = 1'b0;
        a_if_req = 0; a_if_addr = 0; a_mem_req = 0; a_mem_we = 0;
        a_mem_sel = 0; a_mem_addr = 0; a_mem_wdata = 0;
        b_if_req = 0; b_if_addr = 0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_ce_n", 32'(a_ram_ce_n), 32'h1);
        check("rst_oe_n", 32'(a_ram_oe_n), 32'h1);
        check("rst_we_n", 32'(a_ram_we_n), 32'h1);
        check("rst_be_n", 32'(a_ram_be_n), 32'hF);
        check("rst_addr", 32'(a_ram_addr), 32'h0);
        check("rst_acks", {30'h0, a_if_ack, a_mem_ack}, 32'h0);
        check("rst_if_data", a_if_data, 32'h0);
        check("rst_mem_data", a_mem_data, 32'h0);
        check("rst_bus_released", a_ram_data, 32'h0);
        rst = 1'b0;

        // Table-driven accesses on instance A.
        for (int i = 0; i < 8; i++) begin
            a_access(vecs[i], rdata, lat, oe_cnt, we_cnt, drv_cnt, acks, ra, be, stall_bad);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_ram_addr", i), 32'(ra), 32'(vecs[i].exp_ra));
            check($sformatf("v%0d_be_n", i), 32'(be), 32'(vecs[i].exp_be));
            check($sformatf("v%0d_oe_cycles", i), 32'(oe_cnt), 32'(vecs[i].exp_oe));
            check($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_bus_drive_cycles", i), 32'(drv_cnt), 32'(vecs[i].exp_drv));
            check($sformatf("v%0d_ack_pulses", i), 32'(acks), 32'h1);
            check($sformatf("v%0d_stall_ok", i), 32'(stall_bad), 32'h0);
            if (!vecs[i].we) begin
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            end
        end
        // Each port's data register keeps its last read value.
        check("hold_if_data", a_if_data, 32'hAB08BFD0);
        check("hold_mem_data", a_mem_data, 32'h3C08BFD0);

        // Reset asserted between clock edges during the write pulse.
        @(negedge clk);
        a_mem_req = 1'b1; a_mem_we = 1'b1; a_mem_sel = 4'hF;
        a_mem_addr = 32'h80000200; a_mem_wdata = 32'h55555555;
        found = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!a_ram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        check("rstpulse_reached", 32'(found), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rstpulse_we_n", 32'(a_ram_we_n), 32'h1);
        check("rstpulse_ce_n", 32'(a_ram_ce_n), 32'h1);
        check("rstpulse_bus", a_ram_data, 32'h0);
        check("rstpulse_mem_data", a_mem_data, 32'h0);
        a_mem_req = 1'b0; a_mem_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_mem_ack || a_if_ack) acks++;
        end
        check("rstpulse_no_ack", 32'(acks), 32'h0);

        // Two collisions in a row, both reads.
        for (int c = 0; c < 2; c++) begin
`ifdef SRAM_ARB_RR_EN
            exp_mem_first = (c == 0);
`else
            exp_mem_first = 1'b1;
`endif
            @(negedge clk);
            a_mem_req = 1'b1; a_mem_we = 1'b0; a_mem_sel = 4'hF; a_mem_addr = 32'h80000100;
            a_if_req = 1'b1; a_if_addr = 32'h80000010;
            mem_k = 0; if_k = 0; stall_bad = 1'b0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                st = a_stall;
                if (a_mem_ack) begin
                    if (mem_k == 0) mem_k = k;
                    a_mem_req = 1'b0;
                end
                if (a_if_ack) begin
                    if (if_k == 0) if_k = k;
                    a_if_req = 1'b0;
                end
                pending = (mem_k == 0) || (if_k == 0);
                if (st != pending) stall_bad = 1'b1;
                if (!pending) break;
            end
            check($sformatf("coll%0d_mem_ack_cycle", c), 32'(mem_k), exp_mem_first ? 32'd3 : 32'd7);
            check($sformatf("coll%0d_if_ack_cycle", c), 32'(if_k), exp_mem_first ? 32'd7 : 32'd3);
            check($sformatf("coll%0d_stall", c), 32'(stall_bad), 32'h0);
            check($sformatf("coll%0d_mem_data", c), a_mem_data, 32'h1234BEEF);
            check($sformatf("coll%0d_if_data", c), a_if_data, 32'hAB08BFD0);
        end

        // Request dropped after the first RD cycle still completes once.
        @(negedge clk);
        a_mem_req = 1'b1; a_mem_we = 1'b0; a_mem_sel = 4'hF; a_mem_addr = 32'h80000010;
        acks = 0; ack_k = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) a_mem_req = 1'b0;
            if (a_mem_ack) begin
                acks++;
                ack_k = k;
                check("drop_mem_data", a_mem_data, 32'hAB08BFD0);
            end
        end
        check("drop_ack_pulses", 32'(acks), 32'h1);
        check("drop_ack_cycle", 32'(ack_k), 32'd3);
        check("drop_idle_ce_n", 32'(a_ram_ce_n), 32'h1);

        // Back-to-back IF reads on instance B (single-cycle strobes).
        @(negedge clk);
        b_if_req = 1'b1; b_if_addr = 32'h80000000;
        k1 = 0; k2 = 0; n = 0; oe_cnt = 0; d1 = 0; d2 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!b_ram_oe_n) oe_cnt++;
            if (b_if_ack) begin
                n++;
                if (n == 1) begin
                    k1 = k; d1 = b_if_data; b_if_addr = 32'h80000004;
                end else begin
                    k2 = k; d2 = b_if_data; b_if_req = 1'b0;
                end
            end
            if (n >= 2 && k >= k2 + 1) break;
        end
        check("b2b_first_ack", 32'(k1), 32'd2);
        check("b2b_second_ack", 32'(k2), 32'd5);
        check("b2b_first_data", d1, 32'hA5A50001);
        check("b2b_second_data", d2, 32'h0BADF00D);
        check("b2b_oe_cycles", 32'(oe_cnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
